// File: rtl/cia_seq_pkg.sv
// Shared types for the CIA register-port sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cia_seq_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      CPU_CYC  = 2'd1,
      HOST_CYC = 2'd2,
      HOST_RSP = 2'd3
   } seq_state_t;

   // One queued host register access; data is ignored for reads.
   typedef struct packed {
      logic       rw;
      logic [3:0] rs;
      logic [7:0] data;
   } req_t;

   // Interrupt control register; host reads of it clear CIA interrupt flags.
   localparam logic [3:0] RS_ICR = 4'hD;

endpackage

// File: rtl/cia_seq_fifo.sv
// Generic synchronous FIFO, first-word-fall-through, with occupancy count.
// Latency: a pushed word is visible at pop_dat the clk after the push.
// Backpressure: caller must not push when count==DEPTH nor pop when count==0.
// Ports: clk/reset, push+push_dat, pop, pop_dat (head entry), count.
module cia_seq_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push,
   input  logic [WIDTH-1:0]       push_dat,
   input  logic                   pop,
   output logic [WIDTH-1:0]       pop_dat,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;

   // Storage carries no reset; only pointers and count define validity.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= push_dat;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign pop_dat = mem[rd_ptr];

endmodule

// File: rtl/cia_bus_sequencer.sv
// Shares one CIA register port between the CPU and a queued host register master.
// Latency: a queued host access runs in the next phi2 cycle the CPU leaves free; read data 1 clk after phi2_n.
// Backpressure: req_ready drops when the host FIFO is full; a starved FIFO pulls cpu_rdy low.
// Ports: clk/reset; phi2_p/phi2_n strobes; cpu_* (CPU side, cpu_rdata held, cpu_rdy stall);
//        req_* host request handshake; rsp_valid/rsp_rdata host read result; cia_* to the CIA; host_active.
module cia_bus_sequencer
   import cia_seq_pkg::*;
#(
   parameter int FIFO_DEPTH   = 4,
   parameter int STARVE_LIMIT = 64
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       phi2_p,
   input  logic       phi2_n,
   input  logic       cpu_cs_n,
   input  logic       cpu_rw,
   input  logic [3:0] cpu_rs,
   input  logic [7:0] cpu_wdata,
   output logic [7:0] cpu_rdata,
   output logic       cpu_rdy,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic       req_rw,
   input  logic [3:0] req_rs,
   input  logic [7:0] req_wdata,
   output logic       rsp_valid,
   output logic [7:0] rsp_rdata,
   output logic       cia_cs_n,
   output logic       cia_rw,
   output logic [3:0] cia_rs,
   output logic [7:0] cia_db_in,
   input  logic [7:0] cia_db_out,
   output logic       host_active
);

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam int STV_W = $clog2(STARVE_LIMIT + 1);

   seq_state_t       state, state_nxt;
   req_t             push_req, head_req, host_req;
   logic [CNT_W-1:0] fifo_cnt;
   logic             fifo_empty, fifo_full;
   logic             push, pop;
   logic             cpu_win, host_grant;
   logic             host_own;   // current phi2 cycle belongs to the host
   logic             cyc_rd;     // current phi2 cycle is a read
   logic [STV_W-1:0] starve_cnt;

   assign push_req   = {req_rw, req_rs, req_wdata};
   assign fifo_empty = (fifo_cnt == '0);
   assign fifo_full  = (fifo_cnt == CNT_W'(FIFO_DEPTH));
   assign req_ready  = ~fifo_full;
   assign push       = req_valid & req_ready;

   // fifo_empty is registered, so a push landing on this phi2_p is not yet visible here.
   assign cpu_win    = phi2_p & ~cpu_cs_n;
   assign host_grant = phi2_p & cpu_cs_n & ~fifo_empty;
   assign pop        = host_grant;

   cia_seq_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH ($bits(req_t))
   ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .push     (push),
      .push_dat (push_req),
      .pop      (pop),
      .pop_dat  (head_req),
      .count    (fifo_cnt)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (phi2_p) begin
         if (~cpu_cs_n)       state_nxt = CPU_CYC;
         else if (~fifo_empty) state_nxt = HOST_CYC;
         else                 state_nxt = IDLE;
      end else begin
         case (state)
            HOST_CYC: if (phi2_n) state_nxt = cyc_rd ? HOST_RSP : IDLE;
            HOST_RSP: state_nxt = IDLE;
            default:  state_nxt = state;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         host_own   <= 1'b0;
         host_req   <= '0;
         cyc_rd     <= 1'b0;
         starve_cnt <= '0;
         cpu_rdata  <= '0;
         rsp_rdata  <= '0;
      end else begin
         if (phi2_p) begin
            host_own <= host_grant;
            cyc_rd   <= ~cpu_cs_n ? cpu_rw : (~fifo_empty & head_req.rw);
         end
         if (host_grant) host_req <= head_req;

         // CIA read data is valid at the phi2 falling edge; capture per master.
         if (phi2_n && cyc_rd && state == HOST_CYC) rsp_rdata <= cia_db_out;
         if (phi2_n && cyc_rd && state == CPU_CYC)  cpu_rdata <= cia_db_out;

         if (host_grant || fifo_empty)
            starve_cnt <= '0;
         else if (cpu_win && starve_cnt != STV_W'(STARVE_LIMIT))
            starve_cnt <= starve_cnt + 1'b1;
      end
   end

   assign cpu_rdy     = (starve_cnt != STV_W'(STARVE_LIMIT));
   assign rsp_valid   = (state == HOST_RSP);
   assign host_active = host_own;

   // CPU and idle cycles pass straight through so CPU timing is untouched.
   always_comb begin
      cia_cs_n  = cpu_cs_n;
      cia_rw    = cpu_rw;
      cia_rs    = cpu_rs;
      cia_db_in = cpu_wdata;
      if (host_own) begin
         cia_cs_n  = 1'b0;
         cia_rw    = host_req.rw;
         cia_rs    = host_req.rs;
         cia_db_in = host_req.data;
      end
   end

endmodule

// File: tb/tb_cia_bus_sequencer.sv
// Self-checking bench for cia_bus_sequencer against a transaction-level reference model.
// Latency: each phi2 cycle is 8 clks, phi2_p at clk 0, phi2_n at clk 4.
// Backpressure: host requests are offered continuously from a pending queue until accepted.
module tb_cia_bus_sequencer;
   import cia_seq_pkg::*;

   localparam int FIFO_DEPTH   = 4;
   localparam int STARVE_LIMIT = 64;

   logic       clk = 1'b0;
   logic       reset;
   logic       phi2_p, phi2_n;
   logic       cpu_cs_n, cpu_rw;
   logic [3:0] cpu_rs;
   logic [7:0] cpu_wdata, cpu_rdata;
   logic       cpu_rdy;
   logic       req_valid, req_ready, req_rw;
   logic [3:0] req_rs;
   logic [7:0] req_wdata;
   logic       rsp_valid;
   logic [7:0] rsp_rdata;
   logic       cia_cs_n, cia_rw;
   logic [3:0] cia_rs;
   logic [7:0] cia_db_in, cia_db_out;
   logic       host_active;

   int checks = 0;
   int errors = 0;
   int rsp_pulses = 0;
   int exp_pulses = 0;

   // Reference model state
   req_t       pend_q[$];   // requests the host wants to send
   req_t       mq[$];       // requests accepted by the sequencer, not yet executed
   logic [7:0] mregs [16];  // expected CIA register contents
   logic [7:0] exp_cpu_rdata;
   int         starve;

   // Environment: CIA register file and access log
   logic [7:0] cia_regs [16];
   req_t       acc_q[$];

   always #5 clk = ~clk;

   cia_bus_sequencer #(
      .FIFO_DEPTH   (FIFO_DEPTH),
      .STARVE_LIMIT (STARVE_LIMIT)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .phi2_p      (phi2_p),
      .phi2_n      (phi2_n),
      .cpu_cs_n    (cpu_cs_n),
      .cpu_rw      (cpu_rw),
      .cpu_rs      (cpu_rs),
      .cpu_wdata   (cpu_wdata),
      .cpu_rdata   (cpu_rdata),
      .cpu_rdy     (cpu_rdy),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_rw      (req_rw),
      .req_rs      (req_rs),
      .req_wdata   (req_wdata),
      .rsp_valid   (rsp_valid),
      .rsp_rdata   (rsp_rdata),
      .cia_cs_n    (cia_cs_n),
      .cia_rw      (cia_rw),
      .cia_rs      (cia_rs),
      .cia_db_in   (cia_db_in),
      .cia_db_out  (cia_db_out),
      .host_active (host_active)
   );

   assign cia_db_out = cia_regs[cia_rs];

   // CIA acts on its selected access at the phi2 falling edge.
   always @(negedge clk) begin
      if (reset) begin
         for (int i = 0; i < 16; i++) cia_regs[i] <= 8'(8'h10 + i);
      end else if (phi2_n && cia_cs_n === 1'b0) begin
         acc_q.push_back('{cia_rw, cia_rs, cia_rw ? 8'h00 : cia_db_in});
         if (!cia_rw) cia_regs[cia_rs] <= cia_db_in;
      end
   end

   always @(negedge clk) begin
      if (rsp_valid === 1'b1) rsp_pulses <= rsp_pulses + 1;
   end

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] want);
      checks++;
      assert (obs === want) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, want);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 16; i++) mregs[i] = 8'(8'h10 + i);
      mq.delete();
      pend_q.delete();
      starve = 0;
      exp_cpu_rdata = 8'h00;
   endtask

   // One clk: offer the head pending request, advance, and record acceptance in the model.
   task automatic tick();
      logic acc;
      logic mready;
      if (pend_q.size() > 0) begin
         req_valid = 1'b1;
         {req_rw, req_rs, req_wdata} = pend_q[0];
      end else begin
         req_valid = 1'b0;
      end
      @(negedge clk);
      mready = (mq.size() < FIFO_DEPTH);
      if (req_valid) chk("req_ready", req_ready, mready);
      acc = req_valid && mready;
      @(posedge clk);
      #1;
      if (acc) mq.push_back(pend_q.pop_front());
      req_valid = 1'b0;
   endtask

   task automatic push_now();
      for (int i = 0; i < 20 && pend_q.size() > 0; i++) tick();
      chk("push_timeout", 16'(pend_q.size()), 16'd0);
   endtask

   // One full phi2 cycle with the given CPU bus state, checked against the model.
   task automatic phi2_cyc(input logic cs_n, input logic rw, input logic [3:0] rs, input logic [7:0] wd);
      logic host_g, acc_vld, host_rd;
      req_t hreq, exp_acc;
      cpu_cs_n  = cs_n;
      cpu_rw    = rw;
      cpu_rs    = rs;
      cpu_wdata = wd;
      host_g    = cs_n && (mq.size() > 0);
      hreq      = host_g ? mq[0] : '0;
      acc_vld   = 1'b1;
      host_rd   = 1'b0;
      if (!cs_n) begin
         exp_acc = '{rw, rs, rw ? 8'h00 : wd};
         if (mq.size() > 0) begin
            if (starve < STARVE_LIMIT) starve++;
         end else begin
            starve = 0;
         end
      end else if (host_g) begin
         exp_acc = '{hreq.rw, hreq.rs, hreq.rw ? 8'h00 : hreq.data};
         host_rd = hreq.rw;
         starve  = 0;
      end else begin
         exp_acc = '0;
         acc_vld = 1'b0;
         starve  = 0;
      end

      phi2_p = 1'b1;
      tick();
      phi2_p = 1'b0;
      if (host_g) void'(mq.pop_front());
      chk("host_active", host_active, host_g);
      chk("cpu_rdy", cpu_rdy, starve != STARVE_LIMIT);
      chk("cia_cs_n", cia_cs_n, !acc_vld);
      chk("cia_rs", cia_rs, host_g ? hreq.rs : rs);
      if (host_g && !hreq.rw) chk("cia_db_in", cia_db_in, hreq.data);
      tick();
      tick();
      tick();

      phi2_n = 1'b1;
      tick();
      phi2_n = 1'b0;
      if (acc_vld) begin
         if (exp_acc.rw) begin
            if (!cs_n) exp_cpu_rdata = mregs[exp_acc.rs];
         end else begin
            mregs[exp_acc.rs] = exp_acc.data;
         end
      end
      chk("rsp_valid", rsp_valid, host_rd);
      if (host_rd) begin
         chk("rsp_rdata", rsp_rdata, mregs[exp_acc.rs]);
         exp_pulses++;
      end
      tick();
      chk("rsp_valid_end", rsp_valid, 1'b0);
      tick();
      tick();

      chk("cpu_rdata", cpu_rdata, exp_cpu_rdata);
      chk("access_count", 16'(acc_q.size()), 16'(acc_vld));
      if (acc_vld && acc_q.size() > 0) chk("access", 16'(acc_q[0]), 16'(exp_acc));
      acc_q.delete();
   endtask

   initial begin
      reset     = 1'b1;
      phi2_p    = 1'b0;
      phi2_n    = 1'b0;
      cpu_cs_n  = 1'b1;
      cpu_rw    = 1'b1;
      cpu_rs    = 4'h0;
      cpu_wdata = 8'h00;
      req_valid = 1'b0;
      req_rw    = 1'b0;
      req_rs    = 4'h0;
      req_wdata = 8'h00;
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #1;

      // Reset state
      chk("rst_req_ready", req_ready, 1'b1);
      chk("rst_rsp_valid", rsp_valid, 1'b0);
      chk("rst_rsp_rdata", rsp_rdata, 8'h00);
      chk("rst_cpu_rdata", cpu_rdata, 8'h00);
      chk("rst_cpu_rdy", cpu_rdy, 1'b1);
      chk("rst_host_active", host_active, 1'b0);
      chk("rst_cia_cs_n", cia_cs_n, cpu_cs_n);
      reset = 1'b0;
      tick();

      // Host write on an idle bus: one selected cycle, no response.
      pend_q.push_back('{1'b0, 4'h2, 8'hFF});
      push_now();
      phi2_cyc(1'b1, 1'b1, 4'h0, 8'h00);
      phi2_cyc(1'b1, 1'b1, 4'h0, 8'h00);

      // Host read of 0x5A; CPU read data left alone.
      phi2_cyc(1'b0, 1'b0, 4'h0, 8'h5A);
      pend_q.push_back('{1'b1, 4'h0, 8'h00});
      push_now();
      phi2_cyc(1'b1, 1'b1, 4'h0, 8'h00);

      // CPU ICR read wins over a pending host read, which follows next free cycle.
      phi2_cyc(1'b0, 1'b0, RS_ICR, 8'h81);
      pend_q.push_back('{1'b1, 4'h3, 8'h00});
      push_now();
      phi2_cyc(1'b0, 1'b1, RS_ICR, 8'h00);
      chk("icr_read", cpu_rdata, 8'h81);
      phi2_cyc(1'b1, 1'b1, 4'h0, 8'h00);

      // Starvation: 64 CPU cycles with one queued request.
      pend_q.push_back('{1'b1, 4'h5, 8'h00});
      push_now();
      for (int i = 0; i < STARVE_LIMIT; i++)
         phi2_cyc(1'b0, 1'b1, 4'($urandom_range(0, 15)), 8'h00);
      chk("rdy_starved", cpu_rdy, 1'b0);
      phi2_cyc(1'b1, 1'b1, 4'h0, 8'h00);
      chk("rdy_released", cpu_rdy, 1'b1);

      // Five requests into a four-deep FIFO while the CPU holds the bus.
      for (int i = 0; i < 5; i++)
         pend_q.push_back('{1'b0, 4'(4 + i), 8'($urandom_range(0, 255))});
      phi2_cyc(1'b0, 1'b1, 4'h1, 8'h00);
      chk("full_ready", req_ready, 1'b0);
      phi2_cyc(1'b0, 1'b1, 4'h1, 8'h00);
      for (int i = 0; i < 6; i++) phi2_cyc(1'b1, 1'b1, 4'h0, 8'h00);

      // Randomised traffic from both masters.
      for (int i = 0; i < 150; i++) begin
         if (pend_q.size() < 3 && $urandom_range(0, 2) == 0)
            pend_q.push_back('{1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                               8'($urandom_range(0, 255))});
         phi2_cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
      end
      for (int i = 0; i < 20 && (pend_q.size() > 0 || mq.size() > 0); i++)
         phi2_cyc(1'b1, 1'b1, 4'h0, 8'h00);
      chk("drained", 16'(pend_q.size() + mq.size()), 16'd0);

      // Reset in the response clk of a host read aborts it and drops the FIFO.
      pend_q.push_back('{1'b1, 4'h6, 8'h00});
      pend_q.push_back('{1'b0, 4'h7, 8'h33});
      push_now();
      cpu_cs_n = 1'b1;
      phi2_p = 1'b1;
      tick();
      phi2_p = 1'b0;
      chk("rst_test_grant", host_active, 1'b1);
      tick();
      tick();
      tick();
      phi2_n = 1'b1;
      tick();
      phi2_n = 1'b0;
      reset = 1'b1;
      #1;
      chk("rstmid_rsp_valid", rsp_valid, 1'b0);
      chk("rstmid_rsp_rdata", rsp_rdata, 8'h00);
      chk("rstmid_req_ready", req_ready, 1'b1);
      chk("rstmid_cpu_rdy", cpu_rdy, 1'b1);
      chk("rstmid_host_active", host_active, 1'b0);
      chk("rstmid_cpu_rdata", cpu_rdata, 8'h00);
      chk("rstmid_cia_cs_n", cia_cs_n, 1'b1);
      model_reset();
      tick();
      tick();
      reset = 1'b0;
      tick();
      acc_q.delete();
      phi2_cyc(1'b1, 1'b1, 4'h0, 8'h00);
      phi2_cyc(1'b1, 1'b1, 4'h0, 8'h00);

      chk("rsp_pulses", 16'(rsp_pulses), 16'(exp_pulses));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
